educell_spkgen: RTL and testbench
=================================

Name: educell_spkgen

Overview:
- Per-cell outgoing-spike generator for the EDU mesh; the transmit side of the cell's six-direction spike interface.
- Syndrome cells flood spikes to all six neighbours. Non-syndrome cells latch the arrival direction of the first spike and relay the flood outward after a programmable delay.
- After a match, the block routes a one-hot return token back along the latched direction. This marks the correction path and flags matched sources.
- Neighbour inputs and outputs share one 6-bit direction encoding: bit0 S, bit1 N, bit2 SE, bit3 SW, bit4 NE, bit5 NW.

Parameters:
SPIKE_DELAY, 1, cycles from spike arrival to relay emission; legal range 1..15.
CNT_W, 4, width of the delay counter; must satisfy 2^CNT_W > SPIKE_DELAY.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous round clear; same effect as rst, and rst has priority
synd  input  1  cell holds a syndrome; static during a round
flood_start  input  1  one-cycle pulse that starts the flood round
spike_in  input  6  incoming spikes from neighbours, direction-encoded
ret_in  input  6  incoming return tokens from neighbours, direction-encoded
spike_out  output  6  outgoing spikes, registered, one-cycle pulses
ret_out  output  6  outgoing return token, registered, one-hot, one-cycle pulse
syndir_q  output  6  latched arrival direction, one-hot or zero
on_path  output  1  cell lies on a correction path; sticky until rst/clr
matched  output  1  syndrome cell has been paired; sticky until rst/clr
busy  output  1  high when state is not IDLE and not DONE

Behaviour:
- Reset/clr: state=IDLE, cnt=0. All outputs are 0 the following cycle.
- Direction latch uses fixed priority S > N > SE > SW > NE > NW. Only the single highest-priority set bit is stored.
- States: IDLE, DLY, EMIT, WAITR, RET, DONE. Each state has the behaviour below.
- IDLE:
  - synd=1 & flood_start=1 → EMIT (source).
  - synd=0 & spike_in!=0 → latch syndir_q, cnt=SPIKE_DELAY-1, → DLY.
  - synd=1 ignores spike_in. ret_in is ignored.
- DLY (relay only): cnt==0 → EMIT; else cnt decrements. spike_in and ret_in are ignored.
- EMIT, one cycle:
  - Source: spike_out=6'b111111.
  - Relay: spike_out=~syndir_q (never echoes back toward the sender).
  - Next state → WAITR.
- Relay latency: spike_in sampled at cycle t gives spike_out high during cycle t+SPIKE_DELAY+1. Source latency: flood_start at t gives spike_out at t+1.
- WAITR, relay:
  - Further spike_in is ignored (first arrival wins).
  - ret_in!=0 → on_path=1, → RET.
- WAITR, source:
  - ret_in!=0 → matched=1, → DONE, with no ret_out.
  - Else spike_in!=0 → latch syndir_q by priority, matched=1, on_path=1, → RET.
  - If ret_in and spike_in arrive in the same cycle, ret_in wins.
- RET, one cycle: ret_out=syndir_q, → DONE.
- DONE: inputs are ignored. Only rst/clr leave DONE.
- spike_out and ret_out are 0 in every state except EMIT and RET respectively.
- syndir_q holds its latched value until rst/clr.
- rst/clr asserted in any state aborts the round within one cycle. No partial pulse is emitted in the cycle after rst/clr.
- flood_start with synd=0 is ignored. flood_start outside IDLE is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → all outputs 0, busy=0. Repeat with clr=1 in WAITR → IDLE, syndir_q=0.
- Source flood: synd=1, flood_start at t → spike_out=6'h3F only at t+1, busy=1 at t+1. ret_in=6'h02 at t+4 → matched=1, ret_out stays 0, busy=0.
- Relay with SPIKE_DELAY=3: spike_in=6'b001100 at t → syndir_q=6'b000100 (SE), spike_out=6'b111011 only at t+4. Later spike_in=6'h01 → no effect.
- Relay return: after the previous case, ret_in=6'h10 at t+10 → on_path=1 at t+11, ret_out=6'b000100 at t+11 only, then DONE.
- Source match by spike, then the simultaneity case:
  - Source in WAITR, spike_in=6'b100000 → syndir_q=6'h20, matched=1, on_path=1, ret_out=6'h20 for one cycle.
  - Repeat with spike_in=6'h20 and ret_in=6'h01 in the same cycle → matched=1, ret_out=0.
- Abort: relay in DLY (SPIKE_DELAY=5), clr pulse at cnt=2 → spike_out never asserts. A new spike_in afterwards is handled as a fresh arrival.

Source files
------------

// File: rtl/educell_spkgen.sv
// Outgoing-spike generator for one EDU mesh cell: floods or relays spikes,
// then routes a one-hot return token back along the latched arrival direction.
module educell_spkgen #(
    parameter int SPIKE_DELAY = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       synd,
    input  logic       flood_start,
    input  logic [5:0] spike_in,
    input  logic [5:0] ret_in,
    output logic [5:0] spike_out,
    output logic [5:0] ret_out,
    output logic [5:0] syndir_q,
    output logic       on_path,
    output logic       matched,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DLY   = 3'd1,
        S_EMIT  = 3'd2,
        S_WAITR = 3'd3,
        S_RET   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [5:0]       r_syndir, w_syndir_next;
    logic             r_on_path, w_on_path_next;
    logic             r_matched, w_matched_next;
    logic [5:0]       r_spike_out, w_spike_next;
    logic [5:0]       r_ret_out, w_ret_next;
    logic [5:0]       w_first_dir;

    // Bit 0 (S) has the highest priority, so isolating the lowest set bit
    // yields exactly the single direction to keep.
    assign w_first_dir = spike_in & (~spike_in + 6'd1);

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_syndir_next  = r_syndir;
        w_on_path_next = r_on_path;
        w_matched_next = r_matched;
        case (r_state)
            S_IDLE: begin
                if (synd && flood_start) begin
                    w_state_next = S_EMIT;
                end else if (!synd && (spike_in != 6'd0)) begin
                    w_syndir_next = w_first_dir;
                    w_cnt_next    = CNT_W'(SPIKE_DELAY - 1);
                    w_state_next  = S_DLY;
                end
            end
            S_DLY: begin
                if (r_cnt == '0) begin
                    w_state_next = S_EMIT;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_EMIT: w_state_next = S_WAITR;
            S_WAITR: begin
                if (synd) begin
                    // A returning token beats a simultaneous spike: pairing is done.
                    if (ret_in != 6'd0) begin
                        w_matched_next = 1'b1;
                        w_state_next   = S_DONE;
                    end else if (spike_in != 6'd0) begin
                        w_syndir_next  = w_first_dir;
                        w_matched_next = 1'b1;
                        w_on_path_next = 1'b1;
                        w_state_next   = S_RET;
                    end
                end else if (ret_in != 6'd0) begin
                    w_on_path_next = 1'b1;
                    w_state_next   = S_RET;
                end
            end
            S_RET:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pulse outputs are registered from the next state so they coincide
    // with the EMIT/RET cycle itself.
    always_comb begin
        w_spike_next = 6'd0;
        w_ret_next   = 6'd0;
        if (w_state_next == S_EMIT) begin
            w_spike_next = synd ? 6'h3F : ~w_syndir_next;
        end
        if (w_state_next == S_RET) begin
            w_ret_next = w_syndir_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_syndir    <= 6'd0;
            r_on_path   <= 1'b0;
            r_matched   <= 1'b0;
            r_spike_out <= 6'd0;
            r_ret_out   <= 6'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_syndir    <= w_syndir_next;
            r_on_path   <= w_on_path_next;
            r_matched   <= w_matched_next;
            r_spike_out <= w_spike_next;
            r_ret_out   <= w_ret_next;
        end
    end

    assign spike_out = r_spike_out;
    assign ret_out   = r_ret_out;
    assign syndir_q  = r_syndir;
    assign on_path   = r_on_path;
    assign matched   = r_matched;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_educell_spkgen.sv
// Directed bench for educell_spkgen: one instance with SPIKE_DELAY=3 and one
// with SPIKE_DELAY=5, driven by the same stimulus.
module tb_educell_spkgen;

    logic       clk = 1'b0;
    logic       rst, clr, synd, flood_start;
    logic [5:0] spike_in, ret_in;

    logic [5:0] a_spike, a_ret, a_syndir;
    logic       a_on, a_match, a_busy;
    logic [5:0] b_spike, b_ret, b_syndir;
    logic       b_on, b_match, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    educell_spkgen #(.SPIKE_DELAY(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .clr(clr), .synd(synd), .flood_start(flood_start),
        .spike_in(spike_in), .ret_in(ret_in),
        .spike_out(a_spike), .ret_out(a_ret), .syndir_q(a_syndir),
        .on_path(a_on), .matched(a_match), .busy(a_busy)
    );

    educell_spkgen #(.SPIKE_DELAY(5), .CNT_W(4)) u_dut5 (
        .clk(clk), .rst(rst), .clr(clr), .synd(synd), .flood_start(flood_start),
        .spike_in(spike_in), .ret_in(ret_in),
        .spike_out(b_spike), .ret_out(b_ret), .syndir_q(b_syndir),
        .on_path(b_on), .matched(b_match), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%02h", tag, got);
        end
    endtask

    // Advance one cycle; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        clr = 0; flood_start = 0; spike_in = 6'd0; ret_in = 6'd0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; clr = 0; synd = 1; flood_start = 1; spike_in = 6'h3F; ret_in = 6'h3F;
        #1;
        // Reset with busy inputs held for two cycles
        tick(2);
        check("rst spike_out", 8'(a_spike), 8'h00);
        check("rst ret_out",   8'(a_ret),   8'h00);
        check("rst syndir",    8'(a_syndir), 8'h00);
        check("rst on_path",   8'(a_on),    8'h00);
        check("rst matched",   8'(a_match), 8'h00);
        check("rst busy",      8'(a_busy),  8'h00);
        rst = 0; synd = 0; idle_inputs();
        tick();

        // Source flood, match by return token
        synd = 1; flood_start = 1;          // cycle t
        tick();                              // t+1
        flood_start = 0;
        check("src spike t+1", 8'(a_spike), 8'h3F);
        check("src busy t+1",  8'(a_busy),  8'h01);
        tick();                              // t+2
        check("src spike t+2", 8'(a_spike), 8'h00);
        tick(2);                             // t+4
        ret_in = 6'h02;
        tick();                              // t+5
        ret_in = 6'h00;
        check("src ret matched", 8'(a_match), 8'h01);
        check("src ret ret_out", 8'(a_ret),   8'h00);
        check("src ret busy",    8'(a_busy),  8'h00);
        check("src ret on_path", 8'(a_on),    8'h00);
        tick();
        check("src done ret_out", 8'(a_ret), 8'h00);

        // Relay: SE wins over SW
        synd = 0; do_reset();
        spike_in = 6'b001100;               // cycle t
        tick();                              // t+1
        spike_in = 6'h00;
        check("relay syndir",  8'(a_syndir), 8'h04);
        check("relay busy",    8'(a_busy),   8'h01);
        check("relay spike t+1", 8'(a_spike), 8'h00);
        tick(2);                             // t+3
        check("relay spike t+3", 8'(a_spike), 8'h00);
        tick();                              // t+4
        check("relay spike t+4", 8'(a_spike), 8'h3B);
        check("relay5 spike t+4", 8'(b_spike), 8'h00);
        tick();                              // t+5
        check("relay spike t+5", 8'(a_spike), 8'h00);
        spike_in = 6'h01;                    // late spike must be ignored
        tick();                              // t+6
        spike_in = 6'h00;
        check("relay5 spike t+6", 8'(b_spike), 8'h3B);
        check("relay late syndir", 8'(a_syndir), 8'h04);
        check("relay late spike",  8'(a_spike),  8'h00);
        tick(4);                             // t+10
        ret_in = 6'h10;
        tick();                              // t+11
        ret_in = 6'h00;
        check("relay ret on_path", 8'(a_on),  8'h01);
        check("relay ret ret_out", 8'(a_ret), 8'h04);
        check("relay ret matched", 8'(a_match), 8'h00);
        tick();                              // t+12
        check("relay ret_out t+12", 8'(a_ret),  8'h00);
        check("relay done busy",    8'(a_busy), 8'h00);
        check("relay on_path sticky", 8'(a_on), 8'h01);
        ret_in = 6'h01;
        tick();
        ret_in = 6'h00;
        check("relay done ignores ret", 8'(a_ret), 8'h00);

        // Source matched by an incoming spike
        do_reset();
        synd = 1; flood_start = 1;
        tick();
        flood_start = 0;
        tick();                              // WAITR
        spike_in = 6'b100000;
        tick();
        spike_in = 6'h00;
        check("srcspk syndir",  8'(a_syndir), 8'h20);
        check("srcspk matched", 8'(a_match),  8'h01);
        check("srcspk on_path", 8'(a_on),     8'h01);
        check("srcspk ret_out", 8'(a_ret),    8'h20);
        tick();
        check("srcspk ret_out next", 8'(a_ret), 8'h00);
        check("srcspk busy done",    8'(a_busy), 8'h00);

        // Simultaneous spike and return: return wins, cleared via clr
        clr = 1;
        tick();
        clr = 0;
        check("clr matched", 8'(a_match), 8'h00);
        flood_start = 1;
        tick();
        flood_start = 0;
        tick();
        spike_in = 6'h20; ret_in = 6'h01;
        tick();
        spike_in = 6'h00; ret_in = 6'h00;
        check("simul matched", 8'(a_match),  8'h01);
        check("simul ret_out", 8'(a_ret),    8'h00);
        check("simul on_path", 8'(a_on),     8'h00);
        check("simul syndir",  8'(a_syndir), 8'h00);
        check("simul busy",    8'(a_busy),   8'h00);
        tick();
        check("simul ret_out next", 8'(a_ret), 8'h00);

        // clr while a relay waits for a return
        synd = 0; do_reset();
        spike_in = 6'h02;
        tick();
        spike_in = 6'h00;
        tick(4);                             // t+5: WAITR
        check("waitr busy",   8'(a_busy),   8'h01);
        check("waitr syndir", 8'(a_syndir), 8'h02);
        clr = 1;
        tick();
        clr = 0;
        check("clr waitr busy",   8'(a_busy),   8'h00);
        check("clr waitr syndir", 8'(a_syndir), 8'h00);

        // Abort in DLY (SPIKE_DELAY=5) with clr when cnt==2
        do_reset();
        spike_in = 6'h01;                    // t
        tick();                              // t+1 cnt=4
        spike_in = 6'h00;
        tick(2);                             // t+3 cnt=2
        clr = 1;
        tick();
        clr = 0;
        check("abort busy",   8'(b_busy),   8'h00);
        check("abort syndir", 8'(b_syndir), 8'h00);
        for (int i = 0; i < 6; i++) begin
            check("abort no spike", 8'(b_spike), 8'h00);
            tick();
        end
        spike_in = 6'h08;                    // fresh arrival at t'
        tick();                              // t'+1
        spike_in = 6'h00;
        check("fresh syndir", 8'(b_syndir), 8'h08);
        tick(4);                             // t'+5
        check("fresh spike t+5", 8'(b_spike), 8'h00);
        tick();                              // t'+6
        check("fresh spike t+6", 8'(b_spike), 8'h37);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
